// File: rtl/bcd_counter.sv
// Multi-digit BCD counter with parallel load, sticky wrap flag and load-error pulse.
// Define BCD_COUNTER_DOWN_EN to add down counting selected by dn.
module bcd_counter #(
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clock,
   input  logic                  reset_,
   input  logic                  en,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   din,
   input  logic                  dn,
   output logic [4*DIGITS-1:0]   q,
   output logic                  cout,
   output logic                  ovf,
   output logic                  err
);

   logic [4*DIGITS-1:0] din_clean;
   logic                din_bad;
   logic [4*DIGITS-1:0] q_up;
   logic                carry_out;
   logic [4*DIGITS-1:0] q_next;
   logic                wrap;

   // Invalid load digits become 0 so q never holds a digit above 9.
   always_comb begin : load_sanitize
      din_clean = '0;
      din_bad   = 1'b0;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (din[4*k +: 4] > 4'd9) begin
            din_bad = 1'b1;
         end else begin
            din_clean[4*k +: 4] = din[4*k +: 4];
         end
      end
   end

   // Carry ripples combinationally through every digit, so a step takes one cycle.
   always_comb begin : up_step
      logic carry;
      carry = 1'b1;
      q_up  = q;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (carry) begin
            if (q[4*k +: 4] == 4'd9) begin
               q_up[4*k +: 4] = '0;
            end else begin
               q_up[4*k +: 4] = q[4*k +: 4] + 4'd1;
               carry          = 1'b0;
            end
         end
      end
      carry_out = carry;
   end

`ifdef BCD_COUNTER_DOWN_EN
   logic [4*DIGITS-1:0] q_down;
   logic                borrow_out;

   always_comb begin : down_step
      logic borrow;
      borrow = 1'b1;
      q_down = q;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (borrow) begin
            if (q[4*k +: 4] == 4'd0) begin
               q_down[4*k +: 4] = 4'd9;
            end else begin
               q_down[4*k +: 4] = q[4*k +: 4] - 4'd1;
               borrow           = 1'b0;
            end
         end
      end
      borrow_out = borrow;
   end

   always_comb begin : dir_select
      q_next = q_up;
      wrap   = carry_out;
      if (dn) begin
         q_next = q_down;
         wrap   = borrow_out;
      end
   end
`else
   logic unused_dn;
   assign unused_dn = dn;

   always_comb begin : dir_select
      q_next = q_up;
      wrap   = carry_out;
   end
`endif

   always_ff @(posedge clock) begin
      if (!reset_) begin
         q    <= '0;
         cout <= 1'b0;
         ovf  <= 1'b0;
         err  <= 1'b0;
      end else if (load) begin
         q    <= din_clean;
         cout <= 1'b0;
         ovf  <= 1'b0;
         err  <= din_bad;
      end else if (en) begin
         q    <= q_next;
         cout <= wrap;
         ovf  <= ovf | wrap;
         err  <= 1'b0;
      end else begin
         cout <= 1'b0;
         err  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench for bcd_counter: directed scenarios plus randomized stimulus
// against an integer-arithmetic model of the counter value.
module tb_bcd_counter;

   localparam int DIGITS = 4;
   localparam int W      = 4 * DIGITS;

   logic          clock = 1'b0;
   logic          reset_;
   logic          en;
   logic          load;
   logic [W-1:0]  din;
   logic          dn;
   logic [W-1:0]  q;
   logic          cout;
   logic          ovf;
   logic          err;

   int checks   = 0;
   int failures = 0;

   // Model state: counter value as a plain decimal integer.
   int m_val  = 0;
   bit m_cout = 0;
   bit m_ovf  = 0;
   bit m_err  = 0;

   bcd_counter #(.DIGITS(DIGITS)) dut (
      .clock  (clock),
      .reset_ (reset_),
      .en     (en),
      .load   (load),
      .din    (din),
      .dn     (dn),
      .q      (q),
      .cout   (cout),
      .ovf    (ovf),
      .err    (err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int pow10(input int n);
      int p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r = '0;
      for (int k = 0; k < DIGITS; k++) begin
         r = r | (W'((v / pow10(k)) % 10) << (4 * k));
      end
      return r;
   endfunction

   // One clock edge: advance the model with the applied inputs, then compare all outputs.
   task automatic step(input string tag);
      int  modv = pow10(DIGITS);
      bit  down = 1'b0;
`ifdef BCD_COUNTER_DOWN_EN
      down = dn;
`endif
      if (!reset_) begin
         m_val = 0; m_cout = 0; m_ovf = 0; m_err = 0;
      end else if (load) begin
         int  v   = 0;
         bit  bad = 0;
         for (int k = 0; k < DIGITS; k++) begin
            int dg = int'((din >> (4 * k)) & W'(15));
            if (dg > 9) begin
               bad = 1;
               dg  = 0;
            end
            v = v + dg * pow10(k);
         end
         m_val = v; m_err = bad; m_cout = 0; m_ovf = 0;
      end else if (en) begin
         bit w;
         if (down) begin
            w     = (m_val == 0);
            m_val = (m_val + modv - 1) % modv;
         end else begin
            w     = (m_val == modv - 1);
            m_val = (m_val + 1) % modv;
         end
         m_cout = w;
         m_ovf  = m_ovf | w;
         m_err  = 0;
      end else begin
         m_cout = 0;
         m_err  = 0;
      end
      @(posedge clock);
      #1;
      check({tag, ".q"},    32'(q),    32'(to_bcd(m_val)));
      check({tag, ".cout"}, 32'(cout), 32'(m_cout));
      check({tag, ".ovf"},  32'(ovf),  32'(m_ovf));
      check({tag, ".err"},  32'(err),  32'(m_err));
   endtask

   task automatic drive(input bit r, input bit l, input bit e, input bit d, input logic [W-1:0] v);
      reset_ = r; load = l; en = e; dn = d; din = v;
   endtask

   initial begin
      drive(0, 0, 0, 0, '0);
      step("reset");
      check("reset_q", 32'(q), 32'h0);

      // Ten up steps from zero
      drive(1, 0, 1, 0, '0);
      for (int i = 0; i < 10; i++) step("up10");
      check("up10_q", 32'(q), 32'h0010);
      check("up10_ovf", 32'(ovf), 32'h0);

      // Up wrap through 9999
      drive(1, 1, 0, 0, 16'h9998);
      step("ld9998");
      drive(1, 0, 1, 0, '0);
      step("to9999");
      check("to9999_q", 32'(q), 32'h9999);
      step("wrap_up");
      check("wrap_up_q", 32'(q), 32'h0000);
      check("wrap_up_cout", 32'(cout), 32'h1);
      drive(1, 0, 0, 0, '0);
      step("hold");
      check("hold_ovf", 32'(ovf), 32'h1);
      check("hold_cout", 32'(cout), 32'h0);

      // Invalid digit on load
      drive(1, 1, 0, 0, 16'h12F4);
      step("ld_bad");
      check("ld_bad_q", 32'(q), 32'h1204);
      check("ld_bad_err", 32'(err), 32'h1);
      drive(1, 0, 0, 0, '0);
      step("err_clr");

      // Load beats a wrap on the same edge
      drive(1, 1, 0, 0, 16'h9999);
      step("ld9999");
      drive(1, 1, 1, 0, 16'h0500);
      step("ld_vs_wrap");
      check("ld_vs_wrap_q", 32'(q), 32'h0500);
      check("ld_vs_wrap_ovf", 32'(ovf), 32'h0);

      // Direction input
      drive(1, 1, 0, 0, 16'h0100);
      step("ld0100");
      drive(1, 0, 1, 1, '0);
      step("dn1");
`ifdef BCD_COUNTER_DOWN_EN
      check("dn1_q", 32'(q), 32'h0099);
      step("dn2");
      check("dn2_q", 32'(q), 32'h0098);
      drive(1, 1, 0, 1, 16'h0000);
      step("ld0000");
      drive(1, 0, 1, 1, '0);
      step("wrap_dn");
      check("wrap_dn_q", 32'(q), 32'h9999);
      check("wrap_dn_cout", 32'(cout), 32'h1);
      check("wrap_dn_ovf", 32'(ovf), 32'h1);
`else
      check("dn1_q", 32'(q), 32'h0101);
      step("dn2");
      check("dn2_q", 32'(q), 32'h0102);
`endif

      // Reset overrides load and enable mid-count
      drive(1, 0, 1, 0, '0);
      step("mid");
      drive(0, 1, 1, 0, 16'h5555);
      step("rst_ovr");
      check("rst_ovr_q", 32'(q), 32'h0000);
      drive(1, 0, 1, 0, '0);
      step("resume");
      check("resume_q", 32'(q), 32'h0001);

      // Randomized traffic, biased toward loads near both wrap points
      for (int i = 0; i < 500; i++) begin
         logic [W-1:0] v;
         int sel = $urandom_range(0, 3);
         v = W'($urandom);
         if (sel == 0) v = 16'h9990 | W'($urandom_range(0, 9));
         if (sel == 1) v = W'($urandom_range(0, 9));
         drive(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 3) != 0), 1'($urandom), v);
         step("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running expected=finished");
      $fatal(1);
   end

endmodule
